// File: rtl/exc_pkg.sv
// Shared definitions for the EXC-stage commit logic: exception codes, flag
// bit positions, FSM state encoding and default vector constants.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Flag vector bit positions, lowest index = highest priority
  localparam int unsigned NFLAGS   = 10;
  localparam int unsigned F_INT    = 0;
  localparam int unsigned F_ADEL   = 1;
  localparam int unsigned F_REFILL = 2;
  localparam int unsigned F_INVAL  = 3;
  localparam int unsigned F_RI     = 4;
  localparam int unsigned F_SYS    = 5;
  localparam int unsigned F_BP     = 6;
  localparam int unsigned F_OV     = 7;
  localparam int unsigned F_ERET   = 8;
  localparam int unsigned F_REFET  = 9;

  typedef enum logic {IDLE, DRAIN} state_e;

  localparam logic [31:0] DEF_EXC_BASE      = 32'hBFC0_0200;
  localparam logic [31:0] DEF_GEN_OFFSET    = 32'h0000_0180;
  localparam logic [31:0] DEF_REFILL_OFFSET = 32'h0000_0000;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder over the EXC flag vector: one-hot select of the
// winning flag plus its ExcCode (0 for eret/refetch, which carry no code).
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [NFLAGS-1:0] flags,
  output logic [NFLAGS-1:0] sel,
  output logic [4:0]        code
);

  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (!found && flags[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    code = '0;
    if (sel[F_INT])                      code = EXC_INT;
    else if (sel[F_ADEL])                code = EXC_ADEL;
    else if (sel[F_REFILL] | sel[F_INVAL]) code = EXC_TLBL;
    else if (sel[F_RI])                  code = EXC_RI;
    else if (sel[F_SYS])                 code = EXC_SYS;
    else if (sel[F_BP])                  code = EXC_BP;
    else if (sel[F_OV])                  code = EXC_OV;
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// EXC-stage exception commit: prioritises flags, flushes the pipeline, owns
// commit-side CP0 state. Define EXC_COMMIT_TLB_EN to decode the TLB flags.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_BASE      = DEF_EXC_BASE,
  parameter logic [31:0] GEN_OFFSET    = DEF_GEN_OFFSET,
  parameter logic [31:0] REFILL_OFFSET = DEF_REFILL_OFFSET,
  parameter int unsigned DRAIN_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic        exc_is_int,
  input  logic        exc_is_inst_adel,
  input  logic        exc_is_i_refill_tlbl,
  input  logic        exc_is_i_invalid_tlbl,
  input  logic        exc_is_ri,
  input  logic        exc_is_syscall,
  input  logic        exc_is_break,
  input  logic        exc_ov,
  input  logic        exc_is_eret,
  input  logic        exc_is_refetch,
  output logic        exception_flush,
  output logic [31:0] exc_target,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_cause_bd,
  output logic [4:0]  cp0_cause_exccode,
  output logic        cp0_status_exl,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d, bad_q, bad_d;
  logic        bd_q, bd_d, exl_q, exl_d;
  logic [4:0]  code_q, code_d;

  logic [NFLAGS-1:0] flags, sel;
  logic [4:0]        enc_code;
  logic              take, is_exc, tlb_refill, tlb_inval;

`ifdef EXC_COMMIT_TLB_EN
  assign tlb_refill = exc_is_i_refill_tlbl;
  assign tlb_inval  = exc_is_i_invalid_tlbl;
`else
  // Ports stay for drop-in compatibility but can never raise a take
  assign tlb_refill = exc_is_i_refill_tlbl & 1'b0;
  assign tlb_inval  = exc_is_i_invalid_tlbl & 1'b0;
`endif

  assign flags = {exc_is_refetch, exc_is_eret, exc_ov, exc_is_break,
                  exc_is_syscall, exc_is_ri, tlb_inval, tlb_refill,
                  exc_is_inst_adel, exc_is_int};

  exc_prio_enc u_prio (
    .flags (flags),
    .sel   (sel),
    .code  (enc_code)
  );

  assign take   = (|flags) && !stall && (state_q == IDLE);
  assign is_exc = |sel[F_OV:F_INT];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    epc_d           = epc_q;
    bad_d           = bad_q;
    bd_d            = bd_q;
    exl_d           = exl_q;
    code_d          = code_q;
    exception_flush = take;
    exc_target      = '0;

    if (state_q == DRAIN) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - 3'd1;
    end

    if (take) begin
      state_d = DRAIN;
      cnt_d   = 3'(DRAIN_CYCLES - 1);
      if (sel[F_ERET])                  exc_target = epc_q;
      else if (sel[F_REFET])            exc_target = exc_pc;
      else if (sel[F_REFILL] && !exl_q) exc_target = EXC_BASE + REFILL_OFFSET;
      else                              exc_target = EXC_BASE + GEN_OFFSET;

      if (is_exc) begin
        if (!exl_q) begin
          epc_d = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
          bd_d  = exc_in_delay_slot;
        end
        code_d = enc_code;
        exl_d  = 1'b1;
        if (sel[F_ADEL] | sel[F_REFILL] | sel[F_INVAL]) bad_d = exc_pc;
      end else if (sel[F_ERET]) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      bad_q   <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      bd_q    <= bd_d;
      exl_q   <= exl_d;
      code_q  <= code_d;
    end
  end

  assign cp0_epc           = epc_q;
  assign cp0_badvaddr      = bad_q;
  assign cp0_cause_bd      = bd_q;
  assign cp0_cause_exccode = code_q;
  assign cp0_status_exl    = exl_q;
  assign busy              = (state_q == DRAIN);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: vector table through a scoreboard
// queue, plus hand sequences for drain, stall, TLB and reset corner cases.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic        exc_is_int, exc_is_inst_adel, exc_is_i_refill_tlbl;
  logic        exc_is_i_invalid_tlbl, exc_is_ri, exc_is_syscall;
  logic        exc_is_break, exc_ov, exc_is_eret, exc_is_refetch;
  logic        exception_flush;
  logic [31:0] exc_target, cp0_epc, cp0_badvaddr;
  logic        cp0_cause_bd, cp0_status_exl, busy;
  logic [4:0]  cp0_cause_exccode;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall                 (stall),
    .exc_pc                (exc_pc),
    .exc_in_delay_slot     (exc_in_delay_slot),
    .exc_is_int            (exc_is_int),
    .exc_is_inst_adel      (exc_is_inst_adel),
    .exc_is_i_refill_tlbl  (exc_is_i_refill_tlbl),
    .exc_is_i_invalid_tlbl (exc_is_i_invalid_tlbl),
    .exc_is_ri             (exc_is_ri),
    .exc_is_syscall        (exc_is_syscall),
    .exc_is_break          (exc_is_break),
    .exc_ov                (exc_ov),
    .exc_is_eret           (exc_is_eret),
    .exc_is_refetch        (exc_is_refetch),
    .exception_flush       (exception_flush),
    .exc_target            (exc_target),
    .cp0_epc               (cp0_epc),
    .cp0_badvaddr          (cp0_badvaddr),
    .cp0_cause_bd          (cp0_cause_bd),
    .cp0_cause_exccode     (cp0_cause_exccode),
    .cp0_status_exl        (cp0_status_exl),
    .busy                  (busy)
  );

  // Stimulus flag bits: 0 int,1 adel,2 refill,3 invalid,4 ri,5 sys,6 bp,7 ov,8 eret,9 refetch
  typedef struct {
    logic [9:0]  fl;
    logic [31:0] pc;
    logic        bd;
    logic        exp_flush;
    logic [31:0] exp_target;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [4:0]  exp_code;
    logic        exp_exl;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vecs[17];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_flags(input logic [9:0] fl, input logic [31:0] pc, input logic bd);
    exc_is_int            = fl[0];
    exc_is_inst_adel      = fl[1];
    exc_is_i_refill_tlbl  = fl[2];
    exc_is_i_invalid_tlbl = fl[3];
    exc_is_ri             = fl[4];
    exc_is_syscall        = fl[5];
    exc_is_break          = fl[6];
    exc_ov                = fl[7];
    exc_is_eret           = fl[8];
    exc_is_refetch        = fl[9];
    exc_pc                = pc;
    exc_in_delay_slot     = bd;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One take cycle followed by an eret to drop EXL again
  task automatic do_eret(input logic [31:0] exp_tgt);
    @(negedge clk);
    set_flags(10'h100, 32'h0, 1'b0);
    #1;
    chk("eret_flush", {31'd0, exception_flush}, 32'd1);
    chk("eret_target", exc_target, exp_tgt);
    @(posedge clk); #1;
    set_flags('0, 32'h0, 1'b0);
    chk("eret_exl", {31'd0, cp0_status_exl}, 32'd0);
    wait_idle();
  endtask

  function automatic vec_t mk(input logic [9:0] fl, input logic [31:0] pc, input logic bd,
                              input logic f, input logic [31:0] t, input logic [31:0] e,
                              input logic b, input logic [4:0] c, input logic x,
                              input logic [31:0] bv);
    vec_t v;
    v.fl = fl; v.pc = pc; v.bd = bd; v.exp_flush = f; v.exp_target = t;
    v.exp_epc = e; v.exp_bd = b; v.exp_code = c; v.exp_exl = x; v.exp_bad = bv;
    return v;
  endfunction

  initial begin
    vec_t e;
    logic [31:0] gen;
    gen = 32'hBFC0_0380;

    vecs[0]  = mk(10'h020, 32'hBFC0_1000, 0, 1, gen,          32'hBFC0_1000, 0, 8,  1, 0);
    vecs[1]  = mk(10'h100, 32'h0,         0, 1, 32'hBFC0_1000, 32'hBFC0_1000, 0, 8,  0, 0);
    vecs[2]  = mk(10'h010, 32'h8000_0104, 1, 1, gen,          32'h8000_0100, 1, 10, 1, 0);
    vecs[3]  = mk(10'h020, 32'h8000_2000, 0, 1, gen,          32'h8000_0100, 1, 8,  1, 0);
    vecs[4]  = mk(10'h100, 32'h0,         0, 1, 32'h8000_0100, 32'h8000_0100, 1, 8,  0, 0);
    vecs[5]  = mk(10'h181, 32'h1234_5678, 0, 1, gen,          32'h1234_5678, 0, 0,  1, 0);
    vecs[6]  = mk(10'h100, 32'h0,         0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0,  0, 0);
    vecs[7]  = mk(10'h002, 32'h0000_0003, 0, 1, gen,          32'h3,         0, 4,  1, 32'h3);
    vecs[8]  = mk(10'h100, 32'h0,         0, 1, 32'h3,        32'h3,         0, 4,  0, 32'h3);
    vecs[9]  = mk(10'h200, 32'h8000_0040, 0, 1, 32'h8000_0040, 32'h3,        0, 4,  0, 32'h3);
    vecs[10] = mk(10'h000, 32'h0000_5555, 1, 0, 32'h0,        32'h3,         0, 4,  0, 32'h3);
    vecs[11] = mk(10'h080, 32'h0,         1, 1, gen,          32'hFFFF_FFFC, 1, 12, 1, 32'h3);
    vecs[12] = mk(10'h100, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 12, 0, 32'h3);
    vecs[13] = mk(10'h040, 32'h4,         0, 1, gen,          32'h4,         0, 9,  1, 32'h3);
    vecs[14] = mk(10'h100, 32'h0,         0, 1, 32'h4,        32'h4,         0, 9,  0, 32'h3);
    vecs[15] = mk(10'h260, 32'h10,        0, 1, gen,          32'h10,        0, 8,  1, 32'h3);
    vecs[16] = mk(10'h100, 32'h0,         0, 1, 32'h10,       32'h10,        0, 8,  0, 32'h3);

    rst = 1'b1; stall = 1'b0;
    set_flags('0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_epc", cp0_epc, 32'h0);
    chk("rst_bad", cp0_badvaddr, 32'h0);
    chk("rst_cause", {26'd0, cp0_cause_bd, cp0_cause_exccode}, 32'h0);
    chk("rst_exl", {31'd0, cp0_status_exl}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      set_flags(vecs[i].fl, vecs[i].pc, vecs[i].bd);
      sb.push_back(vecs[i]);
      #1;
      chk($sformatf("v%0d_flush", i), {31'd0, exception_flush}, {31'd0, vecs[i].exp_flush});
      chk($sformatf("v%0d_target", i), exc_target, vecs[i].exp_target);
      @(posedge clk); #1;
      set_flags('0, 32'h0, 1'b0);
      e = sb.pop_front();
      chk($sformatf("v%0d_epc", i), cp0_epc, e.exp_epc);
      chk($sformatf("v%0d_bd", i), {31'd0, cp0_cause_bd}, {31'd0, e.exp_bd});
      chk($sformatf("v%0d_code", i), {27'd0, cp0_cause_exccode}, {27'd0, e.exp_code});
      chk($sformatf("v%0d_exl", i), {31'd0, cp0_status_exl}, {31'd0, e.exp_exl});
      chk($sformatf("v%0d_bad", i), cp0_badvaddr, e.exp_bad);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, e.exp_flush});
      wait_idle();
    end

    // Flags held into the drain window must not retrigger
    @(negedge clk);
    set_flags(10'h020, 32'h20, 1'b0);
    #1;
    chk("drain_take", {31'd0, exception_flush}, 32'd1);
    @(posedge clk); #1;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_masked", {31'd0, exception_flush}, 32'd0);
    chk("drain_target0", exc_target, 32'd0);
    set_flags('0, 32'h0, 1'b0);
    wait_idle();
    chk("drain_epc", cp0_epc, 32'h20);
    do_eret(32'h20);

    // Stalled break commits only once stall drops
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_flags(10'h040, 32'h30, 1'b0);
      #1;
      chk("stall_flush", {31'd0, exception_flush}, 32'd0);
      @(posedge clk); #1;
      chk("stall_epc", cp0_epc, 32'h20);
      chk("stall_code", {27'd0, cp0_cause_exccode}, 32'd8);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("unstall_flush", {31'd0, exception_flush}, 32'd1);
    chk("unstall_target", exc_target, 32'hBFC0_0380);
    @(posedge clk); #1;
    set_flags('0, 32'h0, 1'b0);
    chk("unstall_code", {27'd0, cp0_cause_exccode}, 32'd9);
    chk("unstall_epc", cp0_epc, 32'h30);
    wait_idle();
    do_eret(32'h30);

    // Fetch TLB refill at EXL=0
    @(negedge clk);
    set_flags(10'h004, 32'h0040_0000, 1'b0);
    #1;
`ifdef EXC_COMMIT_TLB_EN
    chk("tlb_flush", {31'd0, exception_flush}, 32'd1);
    chk("tlb_target", exc_target, 32'hBFC0_0200);
    @(posedge clk); #1;
    set_flags('0, 32'h0, 1'b0);
    chk("tlb_bad", cp0_badvaddr, 32'h0040_0000);
    chk("tlb_code", {27'd0, cp0_cause_exccode}, 32'd2);
    wait_idle();
    do_eret(32'h0040_0000);
`else
    chk("notlb_flush", {31'd0, exception_flush}, 32'd0);
    @(posedge clk); #1;
    set_flags('0, 32'h0, 1'b0);
    chk("notlb_bad", cp0_badvaddr, 32'h3);
    chk("notlb_busy", {31'd0, busy}, 32'd0);
    chk("notlb_code", {27'd0, cp0_cause_exccode}, 32'd9);
`endif

    // Reset while draining clears state and CP0
    @(negedge clk);
    set_flags(10'h001, 32'h44, 1'b1);
    @(posedge clk); #1;
    set_flags('0, 32'h0, 1'b0);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_epc_pre", cp0_epc, 32'h40);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rd_busy0", {31'd0, busy}, 32'd0);
    chk("rd_epc", cp0_epc, 32'h0);
    chk("rd_bad", cp0_badvaddr, 32'h0);
    chk("rd_exl", {31'd0, cp0_status_exl}, 32'd0);
    chk("rd_cause", {26'd0, cp0_cause_bd, cp0_cause_exccode}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
